// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, reads instruction_memory combinationally
// and queues {pc, word} pairs in a FWFT FIFO that decode drains via valid/ready.
module inst_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [29:0]             imem_addr,
  input  logic [31:0]             imem_data,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic [31:0]             inst,
  output logic [31:0]             inst_pc,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic [31:0]             fetch_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          pop;
  logic          push;

  // A redirect cancels both sides of the handshake in its cycle.
  always_comb begin
    inst_valid = (count != '0);
    pop        = inst_valid && inst_ready && !redirect;
    push       = ((count != FULL) || pop) && !redirect;
    imem_addr  = fetch_pc[31:2];
    inst       = inst_valid ? mem_inst[head] : '0;
    inst_pc    = inst_valid ? mem_pc[head]   : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (push) begin
        tail     <= tail + PTR_ONE;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Storage needs no reset: outputs are gated by count.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_inst[tail] <= imem_data;
      mem_pc[tail]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_inst_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [2:0]  count;
  logic [31:0] fetch_pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_fpc;

  always #5 clock = ~clock;

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return 32'h1000_0000 | pc;
  endfunction

  assign imem_data = data_of({imem_addr, 2'b00});

  inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .count(count), .fetch_pc(fetch_pc)
  );

  // Model the edge: reset > redirect > (pop, push) using the FIFO contents directly.
  task automatic model_step();
    bit do_pop;
    if (reset) begin
      m_q.delete();
      m_fpc = RPC;
    end else if (redirect) begin
      m_q.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      do_pop = (m_q.size() != 0) && inst_ready;
      if (do_pop) void'(m_q.pop_front());
      if (m_q.size() < DEPTH) begin
        m_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; inst_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h1234_5678; inst_ready = 1'b1;
    tick();
    n_checks++;
    if (count !== 3'd0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_count: count=%0d valid=%b required 0/0", count, inst_valid);
    end
    n_checks++;
    if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_head: inst=%h pc=%h required 0/0", inst, inst_pc);
    end
    n_checks++;
    if (fetch_pc !== RPC || imem_addr !== RPC[31:2]) begin
      n_fail++; $display("FAIL reset_pc: fetch_pc=%h required %h", fetch_pc, RPC);
    end
    reset = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_fill();
    int unsigned exp_cnt[6] = '{1, 2, 3, 4, 4, 4};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (count !== 3'(exp_cnt[i])) begin
        n_fail++; $display("FAIL fill_count[%0d]: count=%0d required %0d", i, count, exp_cnt[i]);
      end
    end
    n_checks++;
    if (fetch_pc !== 32'h10) begin
      n_fail++; $display("FAIL fill_fetch_pc: %h required 00000010", fetch_pc);
    end
    n_checks++;
    if (inst_pc !== 32'h0 || inst !== 32'h1000_0000 || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL fill_head: pc=%h inst=%h valid=%b required 0/10000000/1",
                         inst_pc, inst, inst_valid);
    end
  endtask

  task automatic test_pop_push_full();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++; $display("FAIL full_poppush_count: %0d required 4", count);
    end
    n_checks++;
    if (inst_pc !== 32'h4 || inst !== 32'h1000_0004) begin
      n_fail++; $display("FAIL full_poppush_head: pc=%h inst=%h required 4/10000004", inst_pc, inst);
    end
    n_checks++;
    if (fetch_pc !== 32'h14) begin
      n_fail++; $display("FAIL full_poppush_fetch_pc: %h required 00000014", fetch_pc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (inst_pc !== 32'(4 * i) || count !== 3'd1 || inst_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream[%0d]: pc=%h count=%0d valid=%b required %h/1/1",
                           i, inst_pc, count, inst_valid, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++; $display("FAIL redir_prefill: count=%0d required 3", count);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0103; inst_ready = 1'b1;
    tick();
    redirect = 1'b0; inst_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_flush: count=%0d valid=%b required 0/0", count, inst_valid);
    end
    n_checks++;
    if (fetch_pc !== 32'h100) begin
      n_fail++; $display("FAIL redir_fetch_pc: %h required 00000100", fetch_pc);
    end
    tick();
    n_checks++;
    if (inst_pc !== 32'h100 || inst !== 32'h1000_0100 || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL redir_target: pc=%h inst=%h valid=%b required 100/10000100/1",
                         inst_pc, inst, inst_valid);
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc[4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (inst_pc !== exp_pc[i] || inst_valid !== 1'b1) begin
        n_fail++; $display("FAIL wrap[%0d]: pc=%h valid=%b required %h/1",
                           i, inst_pc, inst_valid, exp_pc[i]);
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    redirect = 1'b1; redirect_pc = 32'h0000_0400; inst_ready = 1'b0;
    tick();
    redirect = 1'b0;
    tick(); tick();
    n_checks++;
    if (count !== 3'd2) begin
      n_fail++; $display("FAIL mid_prefill: count=%0d required 2", count);
    end
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0800; inst_ready = 1'b1;
    tick();
    reset = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || fetch_pc !== RPC || inst !== 32'h0 || inst_pc !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: count=%0d fetch_pc=%h inst=%h pc=%h required 0/%h/0/0",
                         count, fetch_pc, inst, inst_pc, RPC);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_inst, e_pc;
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom;
      inst_ready  = ($urandom_range(0, 2) != 0);
      tick();
      e_pc   = (m_q.size() != 0) ? m_q[0] : 32'h0;
      e_inst = (m_q.size() != 0) ? data_of(m_q[0]) : 32'h0;
      n_checks++;
      if (count !== 3'(m_q.size()) || inst_valid !== (m_q.size() != 0) ||
          inst_pc !== e_pc || inst !== e_inst || fetch_pc !== m_fpc) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%0d valid=%b pc=%h inst=%h fpc=%h required %0d/%b/%h/%h/%h",
                 i, count, inst_valid, inst_pc, inst, fetch_pc,
                 m_q.size(), (m_q.size() != 0), e_pc, e_inst, m_fpc);
      end
    end
    reset = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    m_fpc = RPC;
    #1;
    test_reset();
    test_fill();
    test_pop_push_full();
    test_stream();
    test_redirect_flush();
    test_pc_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
